// File: rtl/level_pkg.sv
// level_pkg: shared definitions for the level-control front end.
//   LVL_* : 2-bit level codes seen by the downstream machine.
//   lic_out_t : registered output bundle of the conditioner.
//   therm_to_lvl : sensor thermometer code -> {legal, level}.
package level_pkg;

  localparam logic [1:0] LVL_EMPTY = 2'd0;
  localparam logic [1:0] LVL_LOW   = 2'd1;
  localparam logic [1:0] LVL_MID   = 2'd2;
  localparam logic [1:0] LVL_FULL  = 2'd3;

  typedef struct packed {
    logic [1:0] b;
    logic [1:0] v;
    logic       e;
    logic       fault;
    logic       upd;
  } lic_out_t;

  // Bit0 is the lowest probe; only contiguous-from-bottom wet patterns are legal.
  function automatic logic [2:0] therm_to_lvl(input logic [2:0] t);
    case (t)
      3'b000:  return {1'b1, LVL_EMPTY};
      3'b001:  return {1'b1, LVL_LOW};
      3'b011:  return {1'b1, LVL_MID};
      3'b111:  return {1'b1, LVL_FULL};
      default: return {1'b0, LVL_EMPTY};
    endcase
  endfunction

endpackage

// File: rtl/level_input_conditioner_debounce_bit.sv
// debounce_bit: synchroniser chain + consecutive-cycle debounce for one raw bit.
//   clk, rst  : clock, async active-high reset
//   raw_i     : asynchronous raw input
//   deb_o     : debounced value
//   pending_o : synchronised value currently differs from deb_o
module debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o,
  output logic pending_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic                   deb_q, deb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign syn = sync_q[SYNC_STAGES-1];

  // Counter only runs while syn disagrees with deb; any agreement clears it,
  // so a bounce throws away the partial count. It never passes CNT_MAX.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (syn != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = ~deb_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o     = deb_q;
  assign pending_o = syn ^ deb_q;

endmodule

// File: rtl/level_input_conditioner.sv
// level_input_conditioner: synchronise/debounce selector, enable and sensor
// inputs and present registered codes to the level-control machine.
//   clk, rst   : clock, async active-high reset
//   sw_raw     : raw selector switches (-> b)
//   en_raw     : raw enable switch
//   sens_raw   : raw level probes, bit0 lowest, 1 = wet
//   b, v       : selected level, measured level
//   e          : qualified enable (settled, legal, deb enable high)
//   fault      : illegal sensor pattern present
//   upd        : one-cycle pulse when b or v changes
module level_input_conditioner
  import level_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  input  logic       en_raw,
  input  logic [2:0] sens_raw,
  output logic [1:0] b,
  output logic [1:0] v,
  output logic       e,
  output logic       fault,
  output logic       upd
);

  localparam int NBITS = 6;

  // Bit layout: [2:0] sensors, [4:3] selector, [5] enable.
  logic [NBITS-1:0] raw, deb, pend;
  logic [2:0]       enc;
  logic             legal;
  lic_out_t         out_q, out_d;

  assign raw = {en_raw, sw_raw, sens_raw};

  for (genvar i = 0; i < NBITS; i++) begin : g_deb
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (raw[i]),
      .deb_o     (deb[i]),
      .pending_o (pend[i])
    );
  end

  assign enc   = therm_to_lvl(deb[2:0]);
  assign legal = enc[2];

  always_comb begin
    out_d       = '0;
    out_d.b     = deb[4:3];
    out_d.v     = legal ? enc[1:0] : out_q.v;  // hold last legal level
    out_d.fault = ~legal;
    // Any bit mid-change blocks the enable until everything settles.
    out_d.e     = deb[5] & legal & ~(|pend);
    out_d.upd   = (out_d.b != out_q.b) | (out_d.v != out_q.v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign b     = out_q.b;
  assign v     = out_q.v;
  assign e     = out_q.e;
  assign fault = out_q.fault;
  assign upd   = out_q.upd;

endmodule

// File: tb/tb_level_input_conditioner.sv
module tb_level_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw_raw;
  logic       en_raw;
  logic [2:0] sens_raw;
  logic [1:0] b0, v0, b1, v1;
  logic       e0, f0, u0, e1, f1, u1;

  always #5 clk = ~clk;

  level_input_conditioner u_dut0 (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .en_raw(en_raw), .sens_raw(sens_raw),
    .b(b0), .v(v0), .e(e0), .fault(f0), .upd(u0)
  );

  level_input_conditioner #(.SYNC_STAGES(3), .DEB_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .en_raw(en_raw), .sens_raw(sens_raw),
    .b(b1), .v(v1), .e(e1), .fault(f1), .upd(u1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: raw delay line, syn sample history, and a "last D
  // samples all disagree" acceptance window. Output = {b,v,e,fault,upd}.
  int         SS[2] = '{2, 3};
  int         DD[2] = '{4, 1};
  logic [5:0] rawh [2][8];
  logic [5:0] synh [2][8];
  logic [5:0] m_syn [2];
  logic [5:0] m_deb [2];
  logic [6:0] m_out [2];

  task automatic model_reset(input int m);
    for (int j = 0; j < 8; j++) begin
      rawh[m][j] = '0;
      synh[m][j] = '0;
    end
    m_syn[m] = '0;
    m_deb[m] = '0;
    m_out[m] = '0;
  endtask

  task automatic model_step(input int m, input logic [5:0] r, input logic rs);
    logic [5:0] os, od, nd;
    logic [2:0] s, s1;
    logic [1:0] nb, nv, ob, ov;
    logic       lg, en, up;
    bit         all_diff;
    if (rs) begin
      model_reset(m);
      return;
    end
    os = m_syn[m];
    od = m_deb[m];
    for (int j = 7; j > 0; j--) begin
      rawh[m][j] = rawh[m][j-1];
      synh[m][j] = synh[m][j-1];
    end
    rawh[m][0] = r;
    synh[m][0] = os;
    m_syn[m]   = rawh[m][SS[m]-1];
    nd = od;
    for (int i = 0; i < 6; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DD[m]; j++)
        if (synh[m][j][i] == od[i]) all_diff = 1'b0;
      if (all_diff) nd[i] = ~od[i];
    end
    m_deb[m] = nd;
    s  = od[2:0];
    s1 = s + 3'd1;
    lg = ((s & s1) == 3'd0);
    ob = m_out[m][6:5];
    ov = m_out[m][4:3];
    nb = od[4:3];
    nv = lg ? 2'($countones(s)) : ov;
    en = od[5] & lg & (os == od);
    up = (nb != ob) || (nv != ov);
    m_out[m] = {nb, nv, en, ~lg, up};
  endtask

  task automatic tick();
    logic [5:0] r;
    logic       rs;
    @(posedge clk);
    r  = {en_raw, sw_raw, sens_raw};
    rs = rst;
    #1;
    model_step(0, r, rs);
    model_step(1, r, rs);
    check("inst0_outs", 32'({b0, v0, e0, f0, u0}), 32'(m_out[0]));
    check("inst1_outs", 32'({b1, v1, e1, f1, u1}), 32'(m_out[1]));
  endtask

  task automatic drive(input logic [1:0] sw, input logic en, input logic [2:0] sn);
    sw_raw   = sw;
    en_raw   = en;
    sens_raw = sn;
  endtask

  typedef struct {
    logic [1:0] sw;
    logic       en;
    logic [2:0] sens;
    logic [1:0] eb;
    logic [1:0] ev;
    logic       ee;
    logic       ef;
  } vec_t;

  vec_t       tbl [9];
  logic [2:0] fill [3];
  int         n0, n1;

  initial begin
    tbl[0] = '{2'b01, 1'b1, 3'b001, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[1] = '{2'b01, 1'b1, 3'b011, 2'b01, 2'b10, 1'b1, 1'b0};
    tbl[2] = '{2'b01, 1'b1, 3'b101, 2'b01, 2'b10, 1'b0, 1'b1};
    tbl[3] = '{2'b01, 1'b1, 3'b111, 2'b01, 2'b11, 1'b1, 1'b0};
    tbl[4] = '{2'b10, 1'b1, 3'b000, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{2'b10, 1'b0, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 1'b1, 3'b010, 2'b11, 2'b00, 1'b0, 1'b1};
    tbl[7] = '{2'b11, 1'b1, 3'b000, 2'b11, 2'b00, 1'b1, 1'b0};
    tbl[8] = '{2'b11, 1'b1, 3'b100, 2'b11, 2'b00, 1'b0, 1'b1};
    fill[0] = 3'b001;
    fill[1] = 3'b011;
    fill[2] = 3'b111;

    // Reset with all raw inputs high, then clean step.
    rst = 1'b1;
    drive(2'b11, 1'b1, 3'b111);
    model_reset(0);
    model_reset(1);
    repeat (3) begin
      tick();
      check("reset_outs", 32'({b0, v0, e0, f0, u0, b1, v1, e1, f1, u1}), 32'd0);
    end
    rst = 1'b0;
    drive(2'b01, 1'b1, 3'b001);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check("step0_before", 32'({b0, v0}), 32'd0);
      if (k == 7) check("step0_arrive", 32'({b0, v0, e0, u0}), 32'({2'b01, 2'b01, 1'b1, 1'b1}));
      if (k == 8) check("step0_upd_single", 32'(u0), 32'd0);
      if (k == 4) check("step1_before", 32'({b1, v1}), 32'd0);
      if (k == 5) check("step1_arrive", 32'({b1, v1, u1}), 32'({2'b01, 2'b01, 1'b1}));
    end

    // Settled-state vectors.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].sw, tbl[i].en, tbl[i].sens);
      repeat (12) tick();
      check($sformatf("vec%0d_inst0", i), 32'({b0, v0, e0, f0, u0}),
            32'({tbl[i].eb, tbl[i].ev, tbl[i].ee, tbl[i].ef, 1'b0}));
      check($sformatf("vec%0d_inst1", i), 32'({b1, v1, e1, f1, u1}),
            32'({tbl[i].eb, tbl[i].ev, tbl[i].ee, tbl[i].ef, 1'b0}));
    end

    // Bounce on sw[0]: 1,1,0,0,1,1,0,0 then held 1.
    drive(2'b00, 1'b1, 3'b000);
    repeat (12) tick();
    n0 = 0;
    n1 = 0;
    for (int t = 0; t < 20; t++) begin
      drive({1'b0, (t < 8) ? logic'(((t / 2) % 2) == 0) : 1'b1}, 1'b1, 3'b000);
      tick();
      n0 += int'(u0);
      n1 += int'(u1);
    end
    check("bounce_upd0", 32'(n0), 32'd1);
    check("bounce_upd1", 32'(n1), 32'd5);
    check("bounce_b0", 32'(b0), 32'd1);

    // Sequential fill.
    n0 = 0;
    for (int s = 0; s < 3; s++) begin
      drive(2'b01, 1'b1, fill[s]);
      for (int k = 1; k <= 10; k++) begin
        tick();
        n0 += int'(u0);
        if (k == 6) check("fill_hold", 32'(v0), 32'(s));
        if (k == 7) check("fill_arrive", 32'({v0, u0}), 32'({2'(s + 1), 1'b1}));
      end
    end
    check("fill_upd_count", 32'(n0), 32'd3);

    // Asynchronous reset mid-debounce, then full latency from scratch.
    drive(2'b10, 1'b1, 3'b111);
    repeat (4) tick();
    #3 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check("async_rst", 32'({b0, v0, e0, f0, u0, b1, v1, e1, f1, u1}), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check("rst_step0_before", 32'(b0), 32'd0);
      if (k == 7) check("rst_step0_arrive", 32'({b0, v0, e0, u0}), 32'({2'b10, 2'b11, 1'b1, 1'b1}));
      if (k == 4) check("rst_step1_before", 32'(b1), 32'd0);
      if (k == 5) check("rst_step1_arrive", 32'(b1), 32'd2);
    end

    // One-cycle glitch: rejected by the 4-cycle filter, passed by the 1-cycle one.
    repeat (4) tick();
    drive(2'b11, 1'b1, 3'b111);
    tick();
    drive(2'b10, 1'b1, 3'b111);
    n0 = 0;
    n1 = 0;
    repeat (12) begin
      tick();
      n0 += int'(u0);
      n1 += int'(u1);
    end
    check("glitch_upd0", 32'(n0), 32'd0);
    check("glitch_upd1", 32'(n1), 32'd2);
    check("glitch_b0", 32'(b0), 32'd2);

    // Randomised segments against the model.
    repeat (80) begin
      drive(2'($urandom), 1'($urandom), 3'($urandom));
      repeat ($urandom_range(1, 12)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
